// File: rtl/wb2axil_master.sv
// Wishbone (pipelined) slave to AXI4-Lite master bridge.
// One AXI transaction in flight at a time; the Wishbone side stalls until
// the AXI response returns, then sees a single ack or err pulse.
module wb2axil_master #(
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int LGAXI            = 2,
  localparam int AW              = C_AXI_ADDR_WIDTH,
  localparam int WBAW            = C_AXI_ADDR_WIDTH - LGAXI
) (
  input  logic            i_clk,
  input  logic            i_reset,
  // Wishbone
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [WBAW-1:0] i_wb_addr,
  input  logic [31:0]     i_wb_data,
  input  logic [3:0]      i_wb_sel,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic [31:0]     o_wb_data,
  output logic            o_wb_err,
  // AXI write address
  output logic            o_axi_awvalid,
  input  logic            i_axi_awready,
  output logic [AW-1:0]   o_axi_awaddr,
  // AXI write data
  output logic            o_axi_wvalid,
  input  logic            i_axi_wready,
  output logic [31:0]     o_axi_wdata,
  output logic [3:0]      o_axi_wstrb,
  // AXI write response
  input  logic            i_axi_bvalid,
  output logic            o_axi_bready,
  input  logic [1:0]      i_axi_bresp,
  // AXI read address
  output logic            o_axi_arvalid,
  input  logic            i_axi_arready,
  output logic [AW-1:0]   o_axi_araddr,
  // AXI read data
  input  logic            i_axi_rvalid,
  output logic            o_axi_rready,
  input  logic [31:0]     i_axi_rdata,
  input  logic [1:0]      i_axi_rresp
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t state, state_d;
  logic   accept, done, resp_err, abort;

  // Only bit 1 of the response codes distinguishes OKAY/EXOKAY from errors.
  logic unused_resp_lsb;
  assign unused_resp_lsb = &{1'b0, i_axi_bresp[0], i_axi_rresp[0]};

  assign o_wb_stall = (state != IDLE);

  // Next-state logic plus the per-cycle accept/complete strobes.
  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    done     = 1'b0;
    resp_err = 1'b0;
    case (state)
      IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          accept  = 1'b1;
          state_d = i_wb_we ? WRITE : READ;
        end
      end
      WRITE: begin
        if (i_axi_bvalid) begin
          done     = 1'b1;
          resp_err = i_axi_bresp[1];
          state_d  = IDLE;
        end
      end
      READ: begin
        if (i_axi_rvalid) begin
          done     = 1'b1;
          resp_err = i_axi_rresp[1];
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_d;
  end

  // AXI request valids: raised on accept, each dropped only by its own handshake.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_axi_awvalid <= 1'b0;
      o_axi_wvalid  <= 1'b0;
      o_axi_arvalid <= 1'b0;
    end else if (accept) begin
      o_axi_awvalid <= i_wb_we;
      o_axi_wvalid  <= i_wb_we;
      o_axi_arvalid <= !i_wb_we;
    end else begin
      if (o_axi_awvalid && i_axi_awready) o_axi_awvalid <= 1'b0;
      if (o_axi_wvalid && i_axi_wready)   o_axi_wvalid  <= 1'b0;
      if (o_axi_arvalid && i_axi_arready) o_axi_arvalid <= 1'b0;
    end
  end

  // Request payload; loaded only from IDLE so it is stable while any valid is up.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      o_axi_awaddr <= {i_wb_addr, {LGAXI{1'b0}}};
      o_axi_araddr <= {i_wb_addr, {LGAXI{1'b0}}};
      o_axi_wdata  <= i_wb_data;
      o_axi_wstrb  <= i_wb_sel;
    end
  end

  // Response readies are always open outside reset.
  always_ff @(posedge i_clk) begin
    o_axi_bready <= !i_reset;
    o_axi_rready <= !i_reset;
  end

  // Wishbone response pulse, abort tracking and read data capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_data <= 32'h0;
      abort     <= 1'b0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      if (state == READ && i_axi_rvalid) o_wb_data <= i_axi_rdata;
      if (done) begin
        abort <= 1'b0;
        // A dropped cycle (now or earlier in this transaction) swallows the reply.
        if (!abort && i_wb_cyc) begin
          o_wb_ack <= !resp_err;
          o_wb_err <= resp_err;
        end
      end else if (state != IDLE && !i_wb_cyc) begin
        abort <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb2axil_master.sv
// Randomised scoreboard bench for wb2axil_master with a reactive AXI-Lite slave.
module tb_wb2axil_master;
  localparam int AW = 28;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          cyc, stb, we;
  logic [AW-3:0] wb_addr;
  logic [31:0]   wb_wdata, wb_rdata;
  logic [3:0]    sel;
  logic          stall, ack, err;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  wb2axil_master #(.C_AXI_ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(wb_addr),
    .i_wb_data(wb_wdata), .i_wb_sel(sel), .o_wb_stall(stall), .o_wb_ack(ack),
    .o_wb_data(wb_rdata), .o_wb_err(err),
    .o_axi_awvalid(awvalid), .i_axi_awready(awready), .o_axi_awaddr(awaddr),
    .o_axi_wvalid(wvalid), .i_axi_wready(wready), .o_axi_wdata(wdata), .o_axi_wstrb(wstrb),
    .i_axi_bvalid(bvalid), .o_axi_bready(bready), .i_axi_bresp(bresp),
    .o_axi_arvalid(arvalid), .i_axi_arready(arready), .o_axi_araddr(araddr),
    .i_axi_rvalid(rvalid), .o_axi_rready(rready), .i_axi_rdata(rdata), .i_axi_rresp(rresp)
  );

  typedef struct {
    logic          we;
    logic [AW-3:0] addr;
    logic [31:0]   data;
    logic [3:0]    sel;
    logic [1:0]    resp;
  } axi_t;

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  axi_t        axi_q[$];
  exp_t        exp_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] smem[int];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Slave controls
  bit all_ready = 0;
  bit stray_b   = 0;
  int aw_hold = 0, w_hold = 0, ar_hold = 0;

  // Reactive AXI-Lite slave; works on the falling edge so its decisions are
  // stable across the next rising edge.
  initial begin : slave
    bit            have_aw, have_w, have_ar, p_aw, p_w, p_ar;
    logic [AW-1:0] c_awaddr, c_araddr, p_awaddr, p_araddr;
    logic [31:0]   c_wdata, p_wdata;
    logic [3:0]    c_wstrb, p_wstrb;
    int            dly;
    axi_t          ent;
    have_aw = 0; have_w = 0; have_ar = 0; p_aw = 0; p_w = 0; p_ar = 0; dly = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    forever begin
      @(negedge clk);
      bvalid = 0;
      rvalid = 0;
      if (rst) begin
        have_aw = 0; have_w = 0; have_ar = 0; p_aw = 0; p_w = 0; p_ar = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0;
        awready = 0; wready = 0; arready = 0;
        continue;
      end
      // Stability of requests left waiting at the previous edge
      if (p_aw) begin
        chk("awvalid_held", awvalid, 1);
        chk("awaddr_stable", awaddr, p_awaddr);
      end
      if (p_w) begin
        chk("wvalid_held", wvalid, 1);
        chk("wdata_stable", {wstrb, wdata}, {p_wstrb, p_wdata});
      end
      if (p_ar) begin
        chk("arvalid_held", arvalid, 1);
        chk("araddr_stable", araddr, p_araddr);
      end
      if (stray_b) begin
        bvalid = 1; bresp = 2'b00; stray_b = 0;
      end
      // Responses
      if (have_aw && have_w) begin
        if (dly > 0) dly--;
        else if (axi_q.size() == 0) begin
          chk("write_without_request", 1, 0);
          have_aw = 0; have_w = 0;
        end else begin
          ent = axi_q.pop_front();
          chk("dir_write", ent.we, 1);
          chk("awaddr", c_awaddr, {ent.addr, 2'b00});
          chk("wdata", c_wdata, ent.data);
          chk("wstrb", c_wstrb, ent.sel);
          if (!ent.resp[1])
            smem[int'(c_awaddr)] = merge(smem.exists(int'(c_awaddr)) ? smem[int'(c_awaddr)] : 32'h0,
                                         c_wdata, c_wstrb);
          bresp = ent.resp; bvalid = 1;
          have_aw = 0; have_w = 0;
        end
      end
      if (have_ar) begin
        if (dly > 0) dly--;
        else if (axi_q.size() == 0) begin
          chk("read_without_request", 1, 0);
          have_ar = 0;
        end else begin
          ent = axi_q.pop_front();
          chk("dir_read", ent.we, 0);
          chk("araddr", c_araddr, {ent.addr, 2'b00});
          rdata = smem.exists(int'(c_araddr)) ? smem[int'(c_araddr)] : 32'h0;
          rresp = ent.resp; rvalid = 1;
          have_ar = 0;
        end
      end
      // Readies for the coming edge
      awready = (aw_hold > 0) ? 1'b0 : (all_ready || $urandom_range(0, 2) != 0);
      wready  = (w_hold  > 0) ? 1'b0 : (all_ready || $urandom_range(0, 2) != 0);
      arready = (ar_hold > 0) ? 1'b0 : (all_ready || $urandom_range(0, 2) != 0);
      if (aw_hold > 0) aw_hold--;
      if (w_hold > 0)  w_hold--;
      if (ar_hold > 0) ar_hold--;
      // Handshakes that complete on the coming edge
      if (awvalid && awready && !have_aw) begin
        have_aw = 1; c_awaddr = awaddr; dly = all_ready ? 0 : $urandom_range(0, 3);
      end
      if (wvalid && wready && !have_w) begin
        have_w = 1; c_wdata = wdata; c_wstrb = wstrb; dly = all_ready ? 0 : $urandom_range(0, 3);
      end
      if (arvalid && arready && !have_ar) begin
        have_ar = 1; c_araddr = araddr; dly = all_ready ? 0 : $urandom_range(0, 3);
      end
      p_aw = awvalid && !awready; p_awaddr = awaddr;
      p_w  = wvalid && !wready;   p_wdata  = wdata; p_wstrb = wstrb;
      p_ar = arvalid && !arready; p_araddr = araddr;
    end
  end

  // Monitor: every ack/err pulse is matched against the scoreboard.
  logic cyc_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (ack || err)) begin
      chk("pulse_after_cyc_low", cyc_prev, 1);
      chk("ack_err_exclusive", ack && err, 0);
      if (exp_q.size() == 0) chk("unexpected_pulse", {ack, err}, 2'b00);
      else begin
        e = exp_q.pop_front();
        chk("resp_err", err, e.err);
        chk("resp_ack", ack, !e.err);
        if (e.rd) chk("rdata", wb_rdata, e.data);
      end
    end
    cyc_prev = cyc;
  end

  // Issue one Wishbone request from IDLE; hold>=2 stalls that AXI channel.
  task automatic issue(input bit w, input logic [AW-3:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [1:0] resp, input bit abort,
                       input int hold);
    axi_t x;
    exp_t e;
    int   n;
    x.we = w; x.addr = a; x.data = d; x.sel = s; x.resp = resp;
    axi_q.push_back(x);
    if (!abort) begin
      e.err  = resp[1];
      e.rd   = !w;
      e.data = (!w && ref_mem.exists(int'(a))) ? ref_mem[int'(a)] : 32'h0;
      exp_q.push_back(e);
    end
    if (w && !resp[1])
      ref_mem[int'(a)] = merge(ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0, d, s);
    cyc = 1; stb = 1; we = w; wb_addr = a; wb_wdata = d; sel = s;
    chk("stall_when_idle", stall, 0);
    @(posedge clk); #1;
    stb = 0;
    chk("stall_busy", stall, 1);
    if (w) begin
      chk("awvalid_rise", awvalid, 1);
      chk("wvalid_rise", wvalid, 1);
      chk("awaddr_out", awaddr, {a, 2'b00});
      chk("wdata_out", {wstrb, wdata}, {s, d});
      w_hold = hold;
    end else begin
      chk("arvalid_rise", arvalid, 1);
      chk("araddr_out", araddr, {a, 2'b00});
      ar_hold = hold;
    end
    if (abort) cyc = 0;
    if (all_ready || hold >= 2) begin
      @(posedge clk); #1;
      if (w) begin
        chk("awvalid_one_cycle", awvalid, 0);
        chk("wvalid_after_1", wvalid, hold >= 2);
      end else chk("arvalid_after_1", arvalid, hold >= 2);
    end
    n = 0;
    if (abort) begin
      while (stall && n < 100) begin @(posedge clk); #1; n++; end
      chk("abort_completes", stall, 0);
    end else begin
      while (!(ack || err) && n < 100) begin @(posedge clk); #1; n++; end
      chk("pulse_seen", ack || err, 1);
    end
  endtask

  initial begin : stim
    bit            w, ab;
    logic [AW-3:0] a;
    logic [1:0]    r;
    cyc = 0; stb = 0; we = 0; wb_addr = 0; wb_wdata = 0; sel = 0;
    repeat (2) @(posedge clk);
    #1 cyc = 1; stb = 1; we = 1;
    @(posedge clk); #1;
    // Request held during reset must not raise anything
    chk("rst_stall", stall, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
    chk("rst_readies", {bready, rready}, 2'b00);
    chk("rst_pulses", {ack, err}, 2'b00);
    chk("rst_wb_data", wb_rdata, 0);
    stb = 0; cyc = 0; rst = 0;

    // Directed: first cycle after reset, plain write then read-back
    all_ready = 1;
    issue(1, 26'h10, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0);
    issue(0, 26'h10, 32'h0, 4'h0, 2'b00, 0, 0);
    // Write data held off for three cycles, partial strobes
    issue(1, 26'h10, 32'hCAFEF00D, 4'h5, 2'b00, 0, 3);
    issue(0, 26'h10, 32'h0, 4'h0, 2'b00, 0, 0);
    // Read returning SLVERR still delivers data
    issue(1, 26'h20, 32'h12345678, 4'hF, 2'b00, 0, 0);
    issue(0, 26'h20, 32'h0, 4'h0, 2'b10, 0, 0);
    // Abort a read while arready is held low
    issue(0, 26'h20, 32'h0, 4'h0, 2'b00, 1, 4);
    issue(0, 26'h20, 32'h0, 4'h0, 2'b00, 0, 0);

    // Reset in the middle of a stalled write
    cyc = 1; stb = 1; we = 1; wb_addr = 26'h5; wb_wdata = 32'hA5A5A5A5; sel = 4'hF;
    @(posedge clk); #1;
    stb = 0; aw_hold = 10; w_hold = 10;
    chk("mid_awvalid", awvalid, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_pulses", {ack, err}, 2'b00);
    rst = 0; stray_b = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("stray_b_stall", stall, 0);
    chk("stray_b_pulses", {ack, err}, 2'b00);

    // Randomised traffic
    all_ready = 0;
    repeat (200) begin
      w  = $urandom_range(0, 1);
      a  = ($urandom_range(0, 1) ? 26'h3FFFFF0 : 26'h0) + 26'($urandom_range(0, 15));
      r  = ($urandom_range(0, 3) == 0) ? {1'b1, 1'($urandom_range(0, 1))}
                                       : {1'b0, 1'($urandom_range(0, 1))};
      ab = ($urandom_range(0, 9) == 0);
      issue(w, a, $urandom, 4'($urandom_range(0, 15)), r, ab, 0);
    end

    repeat (6) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("axi_q_drained", axi_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
